pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the five-stage CPU. It replaces the hand-written per-stage D/E/M/W registers with one block that carries a generic payload plus PC+4. It adds a valid/ready handshake, an optional 2-entry skid buffer, and a per-instance stall mode: HOLD or BUBBLE. One instance sits between each pair of adjacent pipeline stages.

---
 rtl/cpu_pipe_pkg.sv | 16 +
 rtl/pipe_slot.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 134 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared constants for the pipeline stage registers.
// Stall-mode codes, occupancy state encoding and the nop instruction.
package cpu_pipe_pkg;

  localparam int STALL_HOLD   = 0;
  localparam int STALL_BUBBLE = 1;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data+pc4 register; clr beats load, else hold.
// Ports: Clk, Reset, clr, load, ld_data/ld_pc4 in; valid/data/pc4 out.
module pipe_slot
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = 96
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [31:0]       ld_pc4,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [31:0]       pc4
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       pc4_q, pc4_d;

  // An empty slot always carries a nop with zero pc4.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc4_d   = pc4_q;
    if (clr) begin
      valid_d = 1'b0;
      data_d  = DATA_W'(NOP_INSTR);
      pc4_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = ld_data;
      pc4_d   = ld_pc4;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign pc4   = pc4_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register, optional 2-deep skid.
// Ports: Clk, Reset, Clr, stall, in_* (upstream), out_* (downstream), count.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W     = 96,
  parameter int STALL_MODE = 0,
  parameter int SKID       = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc4,
  output logic [1:0]        count
);

  localparam bit BUBBLE  = (STALL_MODE == STALL_BUBBLE);
  localparam bit HAS_SKD = (SKID != 0);

  state_e state_q, state_d;

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [31:0]       main_pc4, skid_pc4;

  logic main_clr, main_load, main_from_skid;
  logic skid_clr, skid_load;
  logic in_xfer, out_xfer, flush;

  logic [DATA_W-1:0] main_ld_data;
  logic [31:0]       main_ld_pc4;

  // With a skid slot, ready comes from flops only; without one,
  // out_ready passes straight through.
  assign in_ready = HAS_SKD
    ? (!skid_valid && !stall)
    : ((!main_valid || out_ready) && !stall);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

  // Clr, and a stall in bubble mode, both empty the stage.
  assign flush = Clr || (stall && BUBBLE);

  always_comb begin
    state_d        = state_q;
    main_clr       = 1'b0;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_clr       = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer && HAS_SKD) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (out_xfer) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  assign main_ld_data = main_from_skid ? skid_data : in_data;
  assign main_ld_pc4  = main_from_skid ? skid_pc4  : in_pc4;

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (main_clr),
    .load    (main_load),
    .ld_data (main_ld_data),
    .ld_pc4  (main_ld_pc4),
    .valid   (main_valid),
    .data    (main_data),
    .pc4     (main_pc4)
  );

  // Never loaded when SKID=0, so it stays empty and folds away.
  pipe_slot #(.DATA_W(DATA_W)) u_skid (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (skid_clr),
    .load    (skid_load),
    .ld_data (in_data),
    .ld_pc4  (in_pc4),
    .valid   (skid_valid),
    .data    (skid_data),
    .pc4     (skid_pc4)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_pc4   = main_pc4;
  assign count     = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three configurations against a queue model.
// Instance 0 skid/hold, 1 skid/bubble, 2 no-skid/hold.
module tb_pipe_stage_reg;
  import cpu_pipe_pkg::*;

  localparam int DW = 16;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Clr = 1'b0;
  logic stall = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [31:0] in_pc4 = '0;

  logic [2:0] ir, ov;
  logic [DW-1:0] od [3];
  logic [31:0] op [3];
  logic [1:0] cnt [3];

  int checks = 0;
  int errors = 0;

  int mc [3];
  logic [DW-1:0] md [3][2];
  logic [31:0] mp [3][2];

  always #5 Clk = ~Clk;

  pipe_stage_reg #(
    .DATA_W(DW), .STALL_MODE(STALL_HOLD), .SKID(1)
  ) u0 (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .stall(stall),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_pc4(in_pc4),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_pc4(op[0]), .count(cnt[0])
  );

  pipe_stage_reg #(
    .DATA_W(DW), .STALL_MODE(STALL_BUBBLE), .SKID(1)
  ) u1 (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .stall(stall),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_pc4(in_pc4),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_pc4(op[1]), .count(cnt[1])
  );

  pipe_stage_reg #(
    .DATA_W(DW), .STALL_MODE(STALL_HOLD), .SKID(0)
  ) u2 (
    .Clk(Clk), .Reset(Reset), .Clr(Clr), .stall(stall),
    .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_pc4(in_pc4),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_data(od[2]), .out_pc4(op[2]), .count(cnt[2])
  );

  function automatic bit m_skid(int i);
    return i != 2;
  endfunction

  function automatic bit m_bub(int i);
    return i == 1;
  endfunction

  function automatic bit m_rdy(int i);
    if (stall) return 1'b0;
    if (m_skid(i)) return mc[i] < 2;
    return (mc[i] == 0) || out_ready;
  endfunction

  task automatic chk(string nm, int i, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, i, act, exp);
    end
  endtask

  task automatic set_in(bit v, logic [DW-1:0] d);
    in_valid = v;
    in_data  = d;
    in_pc4   = 32'h1000 + 32'(d) * 4;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 3; i++) mc[i] = 0;
  endtask

  // Advance one clock, updating the queue model from pre-edge inputs.
  task automatic step();
    bit rdy [3];
    for (int i = 0; i < 3; i++) rdy[i] = m_rdy(i);
    @(posedge Clk);
    for (int i = 0; i < 3; i++) begin
      if (Reset || Clr || (stall && m_bub(i))) begin
        mc[i] = 0;
      end else begin
        if (mc[i] > 0 && out_ready) begin
          md[i][0] = md[i][1];
          mp[i][0] = mp[i][1];
          mc[i]--;
        end
        if (in_valid && rdy[i]) begin
          md[i][mc[i]] = in_data;
          mp[i][mc[i]] = in_pc4;
          mc[i]++;
        end
      end
    end
    #1;
  endtask

  always @(negedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, 64'(ov[i]), 64'(mc[i] > 0));
      chk("out_data", i, 64'(od[i]),
          mc[i] > 0 ? 64'(md[i][0]) : 64'd0);
      chk("out_pc4", i, 64'(op[i]),
          mc[i] > 0 ? 64'(mp[i][0]) : 64'd0);
      chk("count", i, 64'(cnt[i]), 64'(mc[i]));
      chk("in_ready", i, 64'(ir[i]), 64'(m_rdy(i)));
    end
  end

  initial begin
    step();
    step();
    Reset = 1'b0;
    chk("rst_valid", 0, 64'(ov[0]), 64'd0);
    chk("rst_data", 0, 64'(od[0]), 64'd0);
    chk("rst_pc4", 0, 64'(op[0]), 64'd0);
    chk("rst_count", 0, 64'(cnt[0]), 64'd0);
    chk("rst_ready", 0, 64'(ir[0]), 64'd1);

    out_ready = 1'b1;
    set_in(1, 16'h11); step();
    chk("s_data", 0, 64'(od[0]), 64'h11);
    chk("s_pc4", 0, 64'(op[0]), 64'h1044);
    chk("s_count", 0, 64'(cnt[0]), 64'd1);
    set_in(1, 16'h22); step();
    chk("s_data", 0, 64'(od[0]), 64'h22);
    set_in(1, 16'h33); step();
    chk("s_data", 0, 64'(od[0]), 64'h33);
    chk("s_count", 0, 64'(cnt[0]), 64'd1);
    chk("s_data", 2, 64'(od[2]), 64'h33);
    set_in(0, 0); step();
    chk("s_drain", 0, 64'(ov[0]), 64'd0);

    out_ready = 1'b0;
    set_in(1, 16'hAA); step();
    set_in(1, 16'hBB); step();
    chk("k_count", 0, 64'(cnt[0]), 64'd2);
    chk("k_ready", 0, 64'(ir[0]), 64'd0);
    chk("k_data", 0, 64'(od[0]), 64'hAA);
    chk("k_count", 2, 64'(cnt[2]), 64'd1);
    set_in(0, 0);
    out_ready = 1'b1; step();
    chk("k_data", 0, 64'(od[0]), 64'hBB);
    chk("k_count", 0, 64'(cnt[0]), 64'd1);
    chk("k_empty", 2, 64'(ov[2]), 64'd0);
    step();
    chk("k_empty", 0, 64'(ov[0]), 64'd0);

    out_ready = 1'b0;
    set_in(1, 16'h55); step();
    stall = 1'b1;
    set_in(1, 16'h66);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("h_data", 0, 64'(od[0]), 64'h55);
      chk("h_valid", 0, 64'(ov[0]), 64'd1);
      chk("h_ready", 0, 64'(ir[0]), 64'd0);
      chk("b_valid", 1, 64'(ov[1]), 64'd0);
      chk("b_data", 1, 64'(od[1]), 64'd0);
    end
    stall = 1'b0; step();
    chk("b_accept", 1, 64'(od[1]), 64'h66);
    chk("h_count", 0, 64'(cnt[0]), 64'd2);
    set_in(0, 0);
    out_ready = 1'b1; step(); step();

    out_ready = 1'b0;
    set_in(1, 16'h01); step();
    set_in(1, 16'h02); step();
    chk("c_count", 0, 64'(cnt[0]), 64'd2);
    Clr = 1'b1; stall = 1'b1;
    set_in(1, 16'h77); step();
    chk("c_count", 0, 64'(cnt[0]), 64'd0);
    chk("c_data", 0, 64'(od[0]), 64'd0);
    chk("c_pc4", 0, 64'(op[0]), 64'd0);
    Clr = 1'b0; stall = 1'b0;
    set_in(0, 0); out_ready = 1'b1;
    step(); step();

    out_ready = 1'b0;
    set_in(1, 16'h05); step();
    Clr = 1'b1;
    set_in(1, 16'h88);
    chk("c_ready", 0, 64'(ir[0]), 64'd1);
    step();
    chk("c_drop", 0, 64'(cnt[0]), 64'd0);
    Clr = 1'b0;
    set_in(0, 0); step();

    set_in(1, 16'h03); step();
    set_in(1, 16'h04); step();
    chk("r_count", 0, 64'(cnt[0]), 64'd2);
    set_in(0, 0);
    #2 Reset = 1'b1;
    #1;
    chk("r_valid", 0, 64'(ov[0]), 64'd0);
    chk("r_count", 0, 64'(cnt[0]), 64'd0);
    m_clear();
    step();
    Reset = 1'b0;
    step();

    for (int k = 0; k < 80; k++) begin
      set_in(1'($urandom_range(0, 1)), DW'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 7) == 0);
      Clr = ($urandom_range(0, 15) == 0);
      step();
    end
    set_in(0, 0);
    stall = 1'b0; Clr = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
